fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Instruction-fetch front end of the multicycle MIPS core. It owns the architectural program counter, computes the sequential next PC, and selects between that value, a branch/jump redirect from execute, and the exception vector. It issues single-outstanding requests to instruction memory and delivers fetched instructions to decode over a valid/ready handshake, with a one-entry skid buffer to absorb decode back-pressure.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `EXC_VECTOR`, default 32'h0000_0180: PC loaded on `exc_valid`.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `imem_req` out 1: fetch request; held until `imem_gnt`.
- `imem_addr` out 32: fetch address; memory samples it only in the cycle with `imem_req && imem_gnt`.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: read data valid, exactly once per granted request, at least 1 cycle after grant.
- `imem_rdata` in 32: instruction word.
- `redirect_valid` in 1: taken branch or jump, single-cycle pulse.
- `redirect_pc` in 32: target; bits [1:0] forced to 0.
- `exc_valid` in 1: exception, single-cycle pulse; priority over redirect.
- `if_valid` out 1: `if_instr`/`if_pc`/`if_pc_plus4` valid.
- `if_ready` in 1: decode accepts when `if_valid && if_ready`.
- `if_instr` out 32, `if_pc` out 32, `if_pc_plus4` out 32: fetched word, its address, and address+4.

## Operation
- FSM states:
  - IDLE: reset state; moves to REQ unconditionally.
  - REQ: `imem_req`=1, `imem_addr`=pc. On `imem_gnt`, go to WAIT.
  - WAIT: await `imem_rvalid`.
  - HOLD: skid buffer full, no requests.
- Response handling in WAIT on `imem_rvalid` with drop=0:
  - Word goes to the output register if it is empty or draining this cycle; otherwise it goes to the skid buffer.
  - pc <= pc+4 (mod 2^32).
  - Next state is REQ, or HOLD if the word went to the skid buffer.
- Response handling in WAIT on `imem_rvalid` with drop=1: word discarded, drop cleared, go to REQ.
- HOLD: on `if_ready`, skid moves to the output register; go to REQ.
- Redirect/exception, in any state except IDLE:
  - pc <= `EXC_VECTOR` if `exc_valid`, else `redirect_pc`&~3.
  - Output register and skid buffer are invalidated the same edge.
  - If a request is outstanding (WAIT, or REQ with `imem_gnt` this cycle), set drop and go or stay in WAIT.
  - Otherwise go to REQ with the new pc.
- Reset values: state IDLE, pc=`RESET_PC`, drop=0, `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_pc_plus4`=0, skid empty.
- Reset asserted mid-transaction: all state clears immediately. A late `imem_rvalid` after reset release, while in IDLE or REQ, is ignored.
- `if_pc_plus4` = `if_pc`+4, truncated to 32 bits.

## Timing
- `imem_req` and `imem_addr` are decoded from registered state and pc; there is no input-to-output combinational path, except `if_ready` into the output-register load enable.
- Best case: REQ with gnt in cycle n, rvalid in cycle n+1, `if_valid` in cycle n+2, next REQ in cycle n+2. Throughput is 1 instruction per 2 cycles.
- `imem_addr` may change while `imem_req` is high without gnt only in the cycle after a redirect or exception.
- Redirect in cycle n: new pc on `imem_addr` at n+1 if nothing is outstanding. A stale `if_valid` never appears after n.
- Back-pressure: at most 2 words are buffered (output register + skid). No word is lost or reordered.

## Structure
- Shared package `mips_fetch_pkg`:
  - state enum (IDLE/REQ/WAIT/HOLD);
  - `RESET_PC_DEFAULT` and `EXC_VECTOR_DEFAULT` constants;
  - a `fetch_pkt_t` struct holding instr, pc and pc_plus4.
- One sub-module, `fetch_skid_buf`: a one-entry buffer with valid/ready plus a flush input. The FSM, pc register and redirect mux stay in the top level.

## Test plan
- Reset with `RESET_PC`=32'h0040_0000: `imem_req`=0 while `rst_n`=0 and in the IDLE cycle, then `imem_req`=1 with `imem_addr`=32'h0040_0000.
- Streaming (gnt immediate, rvalid 1 cycle later, `if_ready`=1): `if_pc` sequence 0x400000, 0x400004, 0x400008, with `if_pc_plus4` = `if_pc`+4 and one valid every 2 cycles.
- `if_ready`=0 for 8 cycles: exactly 2 words are buffered, `imem_req` stays 0 in HOLD, and releasing `if_ready` delivers both words in order, followed by fetch at pc+8.
- `redirect_valid` with `redirect_pc`=32'h0000_0103 during WAIT: the stale response is dropped, `if_valid` never shows it, and the next `imem_addr` is 32'h0000_0100.
- `redirect_valid` and `exc_valid` in the same cycle: the next fetch address is 32'h0000_0180. The same holds when this coincides with `imem_gnt` in REQ (drop set, one response discarded).
- `RESET_PC`=32'hFFFF_FFFC: the second fetch address wraps to 32'h0000_0000, and `if_pc_plus4` reads 0 for the first word.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mips_fetch_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
    } fetch_pkt_t;

    function automatic logic [31:0] pcInc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer for fetched packets, with synchronous flush.
// Latency: 1 cycle from push to outVld.
// Backpressure: inRdy low while full; entry drains when outRdy is high.
module fetch_skid_buf
    import mips_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       inVld,
    output logic       inRdy,
    input  fetch_pkt_t inDat,
    output logic       outVld,
    input  logic       outRdy,
    output fetch_pkt_t outDat
);

    logic       full;
    fetch_pkt_t store;

    assign inRdy  = !full;
    assign outVld = full;
    assign outDat = store;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            store <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (inVld && inRdy) begin
            full  <= 1'b1;
            store <= inDat;
        end else if (outVld && outRdy) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns the PC, issues single-outstanding imem requests, feeds decode.
// Latency: grant in n, rvalid in n+1 gives if_valid in n+2 (one word per 2 cycles).
// Backpressure: output register plus one skid entry; fetching stops while both are full.
module fetch_pc_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_valid,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    logic [1:0]  state;
    logic [31:0] pc;
    logic        drop;
    logic        outVld;
    fetch_pkt_t  outReg;

    logic        flushEvt;
    logic [31:0] flushPc;
    logic        outstanding;
    logic        outFree;
    logic        respTake;
    logic        toOut;
    logic        toSkid;
    logic        skidInRdy;
    logic        skidVld;
    logic        skidPop;
    fetch_pkt_t  respPkt;
    fetch_pkt_t  skidDat;

    assign imem_req  = (state == ST_REQ);
    assign imem_addr = pc;

    assign flushEvt    = (redirect_valid || exc_valid) && (state != ST_IDLE);
    assign flushPc     = exc_valid ? EXC_VECTOR : (redirect_pc & ~32'd3);
    // A response arriving in the same cycle as the flush is consumed here, so it is not outstanding.
    assign outstanding = ((state == ST_WAIT) && !imem_rvalid) || (imem_req && imem_gnt);

    assign outFree  = !outVld || if_ready;
    assign respTake = (state == ST_WAIT) && imem_rvalid && !drop && !flushEvt;
    assign toOut    = respTake && outFree;
    assign toSkid   = respTake && !outFree && skidInRdy;
    assign skidPop  = (state == ST_HOLD) && skidVld && if_ready && !flushEvt;
    assign respPkt  = {imem_rdata, pc, pcInc(pc)};

    fetch_skid_buf u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flushEvt),
        .inVld  (toSkid),
        .inRdy  (skidInRdy),
        .inDat  (respPkt),
        .outVld (skidVld),
        .outRdy (skidPop),
        .outDat (skidDat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            drop  <= 1'b0;
        end else if (flushEvt) begin
            pc    <= flushPc;
            drop  <= outstanding;
            state <= outstanding ? ST_WAIT : ST_REQ;
        end else begin
            case (state)
                ST_IDLE: state <= ST_REQ;
                ST_REQ: begin
                    if (imem_gnt) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            pc    <= pcInc(pc);
                            state <= toSkid ? ST_HOLD : ST_REQ;
                        end
                    end
                end
                ST_HOLD: begin
                    if (if_ready) state <= ST_REQ;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outVld <= 1'b0;
            outReg <= '0;
        end else if (flushEvt) begin
            outVld <= 1'b0;
        end else if (toOut) begin
            outVld <= 1'b1;
            outReg <= respPkt;
        end else if (skidPop) begin
            outVld <= 1'b1;
            outReg <= skidDat;
        end else if (if_ready) begin
            outVld <= 1'b0;
        end
    end

    assign if_valid    = outVld;
    assign if_instr    = outReg.instr;
    assign if_pc       = outReg.pc;
    assign if_pc_plus4 = outReg.pcPlus4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_pc_unit;
    import mips_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] EXC_PC = 32'h0000_0180;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_valid;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    logic        wRst_n;
    logic        wReq;
    logic [31:0] wAddr;
    logic        wGnt;
    logic        wRvalid;
    logic [31:0] wRdata;
    logic        wIfValid;
    logic        wIfReady;
    logic [31:0] wIfInstr;
    logic [31:0] wIfPc;
    logic [31:0] wIfPcPlus4;

    initial forever #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .exc_valid(exc_valid),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
    );

    fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC), .EXC_VECTOR(EXC_PC)) dutWrap (
        .clk(clk), .rst_n(wRst_n),
        .imem_req(wReq), .imem_addr(wAddr), .imem_gnt(wGnt),
        .imem_rvalid(wRvalid), .imem_rdata(wRdata),
        .redirect_valid(1'b0), .redirect_pc(32'd0), .exc_valid(1'b0),
        .if_valid(wIfValid), .if_ready(wIfReady), .if_instr(wIfInstr),
        .if_pc(wIfPc), .if_pc_plus4(wIfPcPlus4)
    );

    int nCmp = 0;
    int nErr = 0;
    bit chkOn = 1'b0;

    // Model: fetched words waiting for decode form a queue of at most two packets.
    bit          mStarted;
    bit          mInFlight;
    bit          mDrop;
    logic [31:0] mPc;
    fetch_pkt_t  mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_req();
        return mStarted && !mInFlight && (mq.size() < 2);
    endfunction

    task automatic model_reset();
        mStarted  = 1'b0;
        mInFlight = 1'b0;
        mDrop     = 1'b0;
        mPc       = RST_PC;
        mq.delete();
    endtask

    task automatic model_step();
        fetch_pkt_t p;
        bit         req;
        bit         pend;
        if (!rst_n) begin
            model_reset();
            return;
        end
        req = m_req();
        if (!mStarted) begin
            mStarted = 1'b1;
            return;
        end
        if (redirect_valid || exc_valid) begin
            mq.delete();
            pend      = (mInFlight && !imem_rvalid) || (req && imem_gnt);
            mInFlight = pend;
            mDrop     = pend;
            mPc       = exc_valid ? EXC_PC : (redirect_pc & 32'hFFFF_FFFC);
            return;
        end
        if (mq.size() > 0 && if_ready) void'(mq.pop_front());
        if (req && imem_gnt) begin
            mInFlight = 1'b1;
        end else if (mInFlight && imem_rvalid) begin
            mInFlight = 1'b0;
            if (mDrop) begin
                mDrop = 1'b0;
            end else begin
                p.instr   = imem_rdata;
                p.pc      = mPc;
                p.pcPlus4 = mPc + 32'd4;
                mq.push_back(p);
                mPc = mPc + 32'd4;
            end
        end
    endtask

    task automatic compare();
        chk("imem_req", 32'(imem_req), 32'(m_req()));
        if (m_req()) chk("imem_addr", imem_addr, mPc);
        chk("if_valid", 32'(if_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("if_instr", if_instr, mq[0].instr);
            chk("if_pc", if_pc, mq[0].pc);
            chk("if_pc_plus4", if_pc_plus4, mq[0].pcPlus4);
        end
    endtask

    always @(negedge clk) if (chkOn) compare();

    task automatic tick_release(input bit relMain, input bit relWrap);
        @(posedge clk);
        model_step();
        #1;
        if (relMain) rst_n = 1'b1;
        if (relWrap) wRst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic tick();
        tick_release(1'b0, 1'b0);
    endtask

    task automatic drive_stream();
        imem_gnt    = m_req();
        imem_rvalid = mInFlight;
        imem_rdata  = $urandom & 32'h7FFF_FFFF;
    endtask

    task automatic drive_rand();
        imem_gnt    = m_req() && ($urandom_range(99) < 60);
        imem_rvalid = mInFlight && ($urandom_range(99) < 50);
        imem_rdata  = $urandom;
        if_ready    = ($urandom_range(99) < 65);
        redirect_pc = $urandom;
        if (redirect_valid || exc_valid) begin
            redirect_valid = 1'b0;
            exc_valid      = 1'b0;
        end else begin
            redirect_valid = ($urandom_range(99) < 4);
            exc_valid      = ($urandom_range(99) < 2);
        end
    endtask

    initial begin
        int          vCyc[3];
        logic [31:0] vPc[3];
        logic [31:0] vP4[3];
        int          nv;
        bit          found;
        bit          sawStale;
        bit          gotFirst;
        logic [31:0] firstPc;

        rst_n = 1'b1; wRst_n = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; exc_valid = 1'b0; if_ready = 1'b0;
        wGnt = 1'b0; wRvalid = 1'b0; wRdata = '0; wIfReady = 1'b1;
        #1;
        rst_n = 1'b0; wRst_n = 1'b0;
        model_reset();
        chkOn = 1'b1;

        // Reset values and the IDLE cycle.
        repeat (2) tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0040_0000);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_pc_plus4", if_pc_plus4, 32'd0);
        tick_release(1'b1, 1'b0);
        chk("idle_req", 32'(imem_req), 32'd0);
        tick();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0040_0000);

        // Streaming at full rate.
        if_ready = 1'b1;
        nv = 0;
        for (int c = 0; c < 14; c++) begin
            drive_stream();
            tick();
            if (if_valid && nv < 3) begin
                vPc[nv] = if_pc; vP4[nv] = if_pc_plus4; vCyc[nv] = c; nv++;
            end
        end
        chk("stream_count", 32'(nv), 32'd3);
        chk("stream_pc0", vPc[0], 32'h0040_0000);
        chk("stream_pc1", vPc[1], 32'h0040_0004);
        chk("stream_pc2", vPc[2], 32'h0040_0008);
        chk("stream_p4_0", vP4[0], 32'h0040_0004);
        chk("stream_gap01", 32'(vCyc[1] - vCyc[0]), 32'd2);
        chk("stream_gap12", 32'(vCyc[2] - vCyc[1]), 32'd2);

        // Exception to a known address, then 8 cycles of decode back-pressure.
        drive_stream();
        exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0;
        if_ready  = 1'b0;
        repeat (8) begin
            drive_stream();
            tick();
        end
        chk("stall_if_valid", 32'(if_valid), 32'd1);
        chk("stall_if_pc", if_pc, 32'h0000_0180);
        chk("stall_req", 32'(imem_req), 32'd0);
        if_ready = 1'b1;
        drive_stream();
        tick();
        chk("release_if_pc", if_pc, 32'h0000_0184);
        chk("release_req", 32'(imem_req), 32'd1);
        chk("release_addr", imem_addr, 32'h0000_0188);

        // Redirect while a response is outstanding.
        imem_rvalid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            imem_gnt = m_req();
            tick();
            found = mInFlight;
        end
        chk("redir_reach_wait", 32'(found), 32'd1);
        imem_gnt = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        chk("redir_no_stale_valid", 32'(if_valid), 32'd0);
        chk("redir_wait_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("redir_addr", 32'(imem_req) ? imem_addr : 32'hFFFF_FFFF, 32'h0000_0100);
        sawStale = 1'b0; gotFirst = 1'b0; firstPc = '0;
        for (int i = 0; i < 8; i++) begin
            drive_stream();
            tick();
            if (if_valid && if_instr == 32'hDEAD_BEEF) sawStale = 1'b1;
            if (if_valid && !gotFirst) begin gotFirst = 1'b1; firstPc = if_pc; end
        end
        chk("redir_stale_seen", 32'(sawStale), 32'd0);
        chk("redir_first_pc", firstPc, 32'h0000_0100);

        // Redirect and exception together during WAIT.
        imem_rvalid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            imem_gnt = m_req();
            tick();
            found = mInFlight;
        end
        chk("both_reach_wait", 32'(found), 32'd1);
        imem_gnt = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; exc_valid = 1'b1;
        tick();
        redirect_valid = 1'b0; exc_valid = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD01;
        tick();
        imem_rvalid = 1'b0;
        chk("both_wait_req", 32'(imem_req), 32'd1);
        chk("both_wait_addr", imem_addr, 32'h0000_0180);

        // Redirect and exception together with a grant in REQ.
        imem_gnt = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; exc_valid = 1'b1;
        tick();
        imem_gnt = 1'b0; redirect_valid = 1'b0; exc_valid = 1'b0;
        chk("both_gnt_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD00;
        tick();
        imem_rvalid = 1'b0;
        chk("both_gnt_dropped", 32'(if_valid), 32'd0);
        chk("both_gnt_addr", imem_addr, 32'h0000_0180);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
        tick();
        imem_rvalid = 1'b0;
        chk("both_gnt_valid", 32'(if_valid), 32'd1);
        chk("both_gnt_pc", if_pc, 32'h0000_0180);
        chk("both_gnt_instr", if_instr, 32'h1111_2222);

        // Randomized traffic with occasional mid-transaction resets and late responses.
        for (int i = 0; i < 4000; i++) begin
            if (i % 1500 == 1499) begin
                rst_n = 1'b0;
                model_reset();
                tick();
                imem_gnt = 1'b0; imem_rvalid = 1'b1;
                redirect_valid = 1'b0; exc_valid = 1'b0;
                tick_release(1'b1, 1'b0);
                tick();
                imem_rvalid = 1'b0;
            end
            drive_rand();
            tick();
        end

        // Wrap of the PC past 2^32 on a separate instance.
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; exc_valid = 1'b0;
        if_ready = 1'b1;
        tick_release(1'b0, 1'b1);
        chk("wrap_idle_req", 32'(wReq), 32'd0);
        tick();
        chk("wrap_req0", 32'(wReq), 32'd1);
        chk("wrap_addr0", wAddr, 32'hFFFF_FFFC);
        wGnt = 1'b1;
        tick();
        wGnt = 1'b0; wRvalid = 1'b1; wRdata = 32'hA5A5_0001;
        chk("wrap_wait_req", 32'(wReq), 32'd0);
        tick();
        wRvalid = 1'b0;
        chk("wrap_if_valid", 32'(wIfValid), 32'd1);
        chk("wrap_if_pc", wIfPc, 32'hFFFF_FFFC);
        chk("wrap_if_pc_plus4", wIfPcPlus4, 32'h0000_0000);
        chk("wrap_if_instr", wIfInstr, 32'hA5A5_0001);
        chk("wrap_req1", 32'(wReq), 32'd1);
        chk("wrap_addr1", wAddr, 32'h0000_0000);

        chkOn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nErr);
        $finish;
    end

endmodule
